// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache for the memory stage.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    localparam int WB       = $clog2(LINE_WORDS);
    localparam int IB       = $clog2(LINES);
    localparam int TAG_BITS = ADDR_WIDTH - 2 - WB - IB;
    localparam int LA_BITS  = ADDR_WIDTH - 2 - WB;
    localparam logic [WB-1:0] LAST_WORD = WB'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_WRITE
    } state_t;

    state_t                  state_q, state_d;
    logic [WB-1:0]           cnt_q, cnt_d;
    logic [LA_BITS-1:0]      line_q, line_d;
    logic [ADDR_WIDTH-3:0]   wa_q, wa_d;
    logic [DATA_WIDTH-1:0]   wd_q, wd_d;
    logic [LINES-1:0]        valid_q;

    logic [TAG_BITS-1:0]     tag_mem  [LINES];
    logic [DATA_WIDTH-1:0]   data_mem [LINES*LINE_WORDS];

    logic [WB-1:0]           in_word;
    logic [IB-1:0]           in_idx;
    logic [TAG_BITS-1:0]     in_tag;
    logic [IB-1:0]           ref_idx;
    logic [TAG_BITS-1:0]     ref_tag;
    logic                    hit;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic                    refill_we;
    logic                    store_hit_we;
    logic                    line_done;
    logic                    miss_start;
    logic                    load_hit;

    logic                    unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr_i[1:0];

    assign in_word = addr_i[WB+1:2];
    assign in_idx  = addr_i[IB+WB+1:WB+2];
    assign in_tag  = addr_i[ADDR_WIDTH-1:IB+WB+2];
    assign ref_idx = line_q[IB-1:0];
    assign ref_tag = line_q[LA_BITS-1:IB];
    assign hit     = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);
    assign rd_word = data_mem[{in_idx, in_word}];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        wa_d         = wa_q;
        wd_d         = wd_q;
        data_o       = '0;
        stall_o      = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        refill_we    = 1'b0;
        store_hit_we = 1'b0;
        line_done    = 1'b0;
        miss_start   = 1'b0;
        load_hit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_en_i) begin
                    stall_o      = 1'b1;
                    store_hit_we = hit;
                    wa_d         = addr_i[ADDR_WIDTH-1:2];
                    wd_d         = data_i;
                    state_d      = S_WRITE;
                end else if (rd_en_i) begin
                    if (hit) begin
                        data_o   = rd_word;
                        load_hit = 1'b1;
                    end else begin
                        stall_o    = 1'b1;
                        miss_start = 1'b1;
                        line_d     = addr_i[ADDR_WIDTH-1:WB+2];
                        cnt_d      = '0;
                        state_d    = S_REFILL;
                    end
                end
            end

            S_REFILL: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {line_q, cnt_q, 2'b00};
                if (mem_ready_i) begin
                    refill_we = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        line_done = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end

            S_WRITE: begin
                // Releasing stall on the completing beat lets the pipeline advance at
                // the same edge, so the store is not re-issued from IDLE.
                stall_o     = !mem_ready_i;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {wa_q, 2'b00};
                mem_wdata_o = wd_q;
                if (mem_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            // The victim line is invalidated up front so a partial refill never hits.
            if (miss_start) begin
                valid_q[in_idx] <= 1'b0;
            end
            if (line_done) begin
                valid_q[ref_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (refill_we) begin
            data_mem[{ref_idx, cnt_q}] <= mem_rdata_i;
        end
        if (line_done) begin
            tag_mem[ref_idx] <= ref_tag;
        end
        if (store_hit_we) begin
            data_mem[{in_idx, in_word}] <= data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (load_hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = load_hit;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed scenarios plus randomized load/store traffic
// against a transaction-level cache and memory model.
module tb_dcache_responder;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int LINES = 16;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en, wr_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata_in;
    logic [DW-1:0] data_out;
    logic          stall;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0]   hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dcache_responder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LINES(LINES),
        .LINE_WORDS(LW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .rd_en_i(rd_en),
        .wr_en_i(wr_en),
        .addr_i(addr),
        .data_i(wdata_in),
        .data_o(data_out),
        .stall_o(stall),
        .mem_req_o(mem_req),
        .mem_we_o(mem_we),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready),
        .mem_rdata_i(mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o(hit_cnt),
        .miss_cnt_o(miss_cnt)
`endif
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Backing memory: written words are remembered, everything else is a fixed hash.
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Cache model in terms of line numbers and tags only.
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    logic [31:0] m_data  [LINES][LW];

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / (4 * LW)) % LINES;
    endfunction
    function automatic int unsigned tag_of(input logic [31:0] a);
        return a / (4 * LW * LINES);
    endfunction
    function automatic int unsigned wrd_of(input logic [31:0] a);
        return (a / 4) % LW;
    endfunction
    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
    } beat_t;

    beat_t       expq[$];
    logic [31:0] beat_log[$];
    int          delay_mode = 0;  // 0: ready tied high, 1: 3 wait cycles per beat, 2: random
    bit          resp_hold = 1'b0;

    initial begin : responder
        beat_t cur;
        bit    have;
        int    wait_left;
        have      = 1'b0;
        wait_left = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (resp_hold || rst || mem_req !== 1'b1) begin
                have = 1'b0;
            end else begin
                if (!have) begin
                    have = 1'b1;
                    if (expq.size() == 0) begin
                        check("beat_expected", 32'd0, 32'd1);
                        cur.addr  = mem_addr;
                        cur.we    = mem_we;
                        cur.wdata = mem_wdata;
                    end else begin
                        cur = expq.pop_front();
                    end
                    check("beat_addr", mem_addr, cur.addr);
                    check("beat_we", {31'd0, mem_we}, {31'd0, cur.we});
                    if (cur.we) check("beat_wdata", mem_wdata, cur.wdata);
                    beat_log.push_back(mem_addr);
                    wait_left = (delay_mode == 0) ? 0 : (delay_mode == 1) ? 3 : $urandom_range(0, 3);
                end else begin
                    check("hold_addr", mem_addr, cur.addr);
                    check("hold_we", {31'd0, mem_we}, {31'd0, cur.we});
                    if (cur.we) check("hold_wdata", mem_wdata, cur.wdata);
                end
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    have      = 1'b0;
                    if (cur.we) mem[cur.addr] = cur.wdata;
                    else mem_rdata = mem_rd(cur.addr);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Every operation starts at negedge+2 and samples at negedge+3.
    task automatic wait_stall(input string name, output int cycles);
        cycles = 0;
        #1;
        while (stall === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
            #3;
        end
        if (cycles >= 200) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic do_load(input logic [31:0] a, output int sc, output logic [31:0] got);
        bit          hit;
        logic [31:0] base;
        hit  = model_hit(a);
        base = a & ~(32'(4 * LW) - 1);
        if (!hit) begin
            for (int w = 0; w < LW; w++) expq.push_back('{base + 32'(4 * w), 1'b0, 32'd0});
        end
        rd_en    = 1'b1;
        wr_en    = 1'b0;
        addr     = a;
        wdata_in = $urandom;
        wait_stall("load", sc);
        if (hit) begin
            check("hit_no_stall", 32'(sc), 32'd0);
        end else begin
            m_valid[idx_of(a)] = 1'b1;
            m_tag[idx_of(a)]   = tag_of(a);
            for (int w = 0; w < LW; w++) m_data[idx_of(a)][w] = mem_rd(base + 32'(4 * w));
            check("refill_beats_done", 32'(expq.size()), 32'd0);
            if (delay_mode == 0) check("miss_penalty", 32'(sc), 32'(LW + 1));
            if (delay_mode == 1) check("miss_penalty_slow", 32'(sc), 32'(1 + 4 * LW));
        end
        got = data_out;
        check("load_data", data_out, m_data[idx_of(a)][wrd_of(a)]);
        check("load_no_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        #2;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int sc);
        if (model_hit(a)) m_data[idx_of(a)][wrd_of(a)] = d;
        expq.push_back('{a & ~32'd3, 1'b1, d});
        wr_en    = 1'b1;
        rd_en    = 1'($urandom);
        addr     = a;
        wdata_in = d;
        wait_stall("store", sc);
        check("write_beat_done", 32'(expq.size()), 32'd0);
        if (delay_mode == 0) check("store_stall", 32'(sc), 32'd1);
        if (delay_mode == 1) check("store_stall_slow", 32'(sc), 32'd4);
        @(negedge clk);
        #2;
    endtask

    task automatic do_idle();
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        addr     = $urandom;
        wdata_in = $urandom;
        #1;
        check("idle_stall", {31'd0, stall}, 32'd0);
        check("idle_data", data_out, 32'd0);
        check("idle_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        #2;
    endtask

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        expq.delete();
    endtask

    initial begin : watchdog
        #3_000_000;
        fails++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : main
        int          sc;
        logic [31:0] got;
        logic [31:0] a;
        int          op;

        clear_model();
        rst      = 1'b1;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        addr     = '0;
        wdata_in = '0;
        mem[32'h40] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_data", data_out, 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #2;

        delay_mode = 0;
        beat_log.delete();
        do_load(32'h40, sc, got);
        check("tp1_data", got, 32'hDEAD_BEEF);
        check("tp1_stall", 32'(sc), 32'd5);
        check("tp1_nbeats", 32'(beat_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < beat_log.size(); i++)
            check("tp1_beat_addr", beat_log[i], 32'h40 + 32'(4 * i));

        beat_log.delete();
        do_load(32'h48, sc, got);
        check("tp2_hit_stall", 32'(sc), 32'd0);
        check("tp2_no_beats", 32'(beat_log.size()), 32'd0);

        beat_log.delete();
        do_store(32'h44, 32'h1234_5678, sc);
        check("tp3_nbeats", 32'(beat_log.size()), 32'd1);
        check("tp3_mem", mem_rd(32'h44), 32'h1234_5678);
        do_load(32'h44, sc, got);
        check("tp3_reload", got, 32'h1234_5678);
        check("tp3_reload_stall", 32'(sc), 32'd0);

        do_store(32'h200, 32'hCAFE_0200, sc);
        beat_log.delete();
        do_load(32'h200, sc, got);
        check("tp4_miss_stall", 32'(sc), 32'd5);
        check("tp4_data", got, 32'hCAFE_0200);
        if (beat_log.size() > 0) check("tp4_first_beat", beat_log[0], 32'h200);
        if (beat_log.size() > 3) check("tp4_last_beat", beat_log[3], 32'h20C);

        do_load(32'h140, sc, got);
        check("tp5_conflict_stall", 32'(sc), 32'd5);
        do_load(32'h40, sc, got);
        check("tp5_reload_stall", 32'(sc), 32'd5);
        check("tp5_reload_data", got, 32'hDEAD_BEEF);

        delay_mode = 1;
        do_load(32'h500, sc, got);
        check("tp6_slow_stall", 32'(sc), 32'd17);

        a = 32'h340;
        for (int w = 0; w < LW; w++) expq.push_back('{a + 32'(4 * w), 1'b0, 32'd0});
        rd_en = 1'b1;
        wr_en = 1'b0;
        addr  = a;
        repeat (6) @(negedge clk);
        #2;
        check("tp6_mid_refill_req", {31'd0, mem_req}, 32'd1);
        rst   = 1'b1;
        rd_en = 1'b0;
        #1;
        check("tp6_rst_req_drop", {31'd0, mem_req}, 32'd0);
        check("tp6_rst_stall", {31'd0, stall}, 32'd0);
        clear_model();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        do_load(a, sc, got);
        check("tp6_after_rst_miss", 32'(sc), 32'd17);

        do_idle();
        for (int n = 0; n < 400; n++) begin
            delay_mode = $urandom_range(0, 2);
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            op = $urandom_range(0, 9);
            if (op == 0) do_idle();
            else if (op <= 3) do_store(a, $urandom, sc);
            else do_load(a, sc, got);
        end
        do_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
